// File: rtl/group_denorm_pkg.sv
// Shared constants, derivation helpers and FSM state type for group_denorm_2d.
// The DEF_* values are the default configuration; the derived constants
// below describe that configuration, and the helpers let the top recompute
// them for any parameter override.
package group_denorm_pkg;

    localparam int DEF_TOTAL_DIM0      = 4;
    localparam int DEF_TOTAL_DIM1      = 4;
    localparam int DEF_COMPUTE_DIM0    = 2;
    localparam int DEF_COMPUTE_DIM1    = 2;
    localparam int DEF_GROUP_CHANNELS  = 2;
    localparam int DEF_IN_WIDTH        = 8;
    localparam int DEF_IN_FRAC_WIDTH   = 4;
    localparam int DEF_STAT_WIDTH      = 8;
    localparam int DEF_STAT_FRAC_WIDTH = 4;
    localparam int DEF_OUT_WIDTH       = 8;
    localparam int DEF_OUT_FRAC_WIDTH  = 4;

    function automatic int calc_num_iters(int t0, int t1, int c0, int c1, int gc);
        return (t0 / c0) * (t1 / c1) * gc;
    endfunction

    function automatic int calc_cnt_width(int iters);
        return (iters > 1) ? $clog2(iters) : 1;
    endfunction

    localparam int NUM_ITERS = calc_num_iters(DEF_TOTAL_DIM0, DEF_TOTAL_DIM1,
                                              DEF_COMPUTE_DIM0, DEF_COMPUTE_DIM1,
                                              DEF_GROUP_CHANNELS);
    localparam int ITER_WIDTH      = calc_cnt_width(NUM_ITERS);
    localparam int PROD_WIDTH      = DEF_IN_WIDTH + DEF_STAT_WIDTH + 1;
    localparam int PROD_FRAC_WIDTH = DEF_IN_FRAC_WIDTH + DEF_STAT_FRAC_WIDTH;
    localparam int SUM_WIDTH       = PROD_WIDTH + 1;

    typedef enum logic {LOAD, RUN} state_e;

endpackage

// File: rtl/fixed_signed_cast.sv
// Signed fixed-point narrowing: floor rounding (arithmetic right shift drops
// fraction bits toward -inf) followed by non-symmetric saturation.
//   din  : IN_WIDTH signed, IN_FRAC_WIDTH fraction bits
//   dout : OUT_WIDTH signed, OUT_FRAC_WIDTH fraction bits
module fixed_signed_cast #(
    parameter int IN_WIDTH       = 18,
    parameter int IN_FRAC_WIDTH  = 8,
    parameter int OUT_WIDTH      = 8,
    parameter int OUT_FRAC_WIDTH = 4
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);
    localparam int SH = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam logic signed [IN_WIDTH-1:0] MAXV =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] MINV =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH-1:0] shifted;

    always_comb begin
        shifted = din >>> SH;
        if (shifted > MAXV)      dout = MAXV[OUT_WIDTH-1:0];
        else if (shifted < MINV) dout = MINV[OUT_WIDTH-1:0];
        else                     dout = shifted[OUT_WIDTH-1:0];
    end
endmodule

// File: rtl/group_denorm_lane.sv
// One lane of the denorm datapath, purely combinational; the top registers
// between the two halves.
//   y, sigma -> prod            : stage-1 multiply y * {0,sigma}
//   prod_s1, mu_s1 -> res       : stage-2 add (mu aligned to prod fraction) + cast
module group_denorm_lane #(
    parameter int IN_WIDTH        = 8,
    parameter int IN_FRAC_WIDTH   = 4,
    parameter int STAT_WIDTH      = 8,
    parameter int OUT_WIDTH       = 8,
    parameter int OUT_FRAC_WIDTH  = 4,
    parameter int PROD_WIDTH      = 17,
    parameter int PROD_FRAC_WIDTH = 8,
    parameter int SUM_WIDTH       = 18
) (
    input  logic signed [IN_WIDTH-1:0]   y,
    input  logic        [STAT_WIDTH-1:0] sigma,
    output logic signed [PROD_WIDTH-1:0] prod,
    input  logic signed [PROD_WIDTH-1:0] prod_s1,
    input  logic signed [STAT_WIDTH-1:0] mu_s1,
    output logic signed [OUT_WIDTH-1:0]  res
);
    logic signed [PROD_WIDTH-1:0] y_ext, sg_ext;
    logic signed [SUM_WIDTH-1:0]  prod_ext, mu_ext, sum;

    // sigma is unsigned: zero-extend so it multiplies as a positive value.
    assign y_ext  = {{(PROD_WIDTH-IN_WIDTH){y[IN_WIDTH-1]}}, y};
    assign sg_ext = {{(PROD_WIDTH-STAT_WIDTH){1'b0}}, sigma};
    assign prod   = y_ext * sg_ext;

    // mu carries STAT_FRAC bits; shifting by IN_FRAC aligns it to prod's fraction.
    assign prod_ext = {{(SUM_WIDTH-PROD_WIDTH){prod_s1[PROD_WIDTH-1]}}, prod_s1};
    assign mu_ext   = {{(SUM_WIDTH-STAT_WIDTH){mu_s1[STAT_WIDTH-1]}}, mu_s1};
    assign sum      = prod_ext + (mu_ext <<< IN_FRAC_WIDTH);

    fixed_signed_cast #(
        .IN_WIDTH      (SUM_WIDTH),
        .IN_FRAC_WIDTH (PROD_FRAC_WIDTH),
        .OUT_WIDTH     (OUT_WIDTH),
        .OUT_FRAC_WIDTH(OUT_FRAC_WIDTH)
    ) u_cast (
        .din (sum),
        .dout(res)
    );
endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer. in_ready comes from a flop, so ready never ripples
// combinationally from out_ready to upstream. out_data is a flop and holds
// while out_valid & !out_ready.
//   in_data/in_valid/in_ready    : upstream handshake
//   out_data/out_valid/out_ready : downstream handshake
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] data_q, data_d, skid_q, skid_d;
    logic             valid_q, valid_d, skid_vld_q, skid_vld_d;

    assign in_ready  = !skid_vld_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (out_ready || !valid_q) begin
            // Output slot frees up: drain the skid entry first, else take input.
            if (skid_vld_q) begin
                data_d     = skid_q;
                valid_d    = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                valid_d = in_valid;
                if (in_valid) data_d = in_data;
            end
        end else if (in_valid && !skid_vld_q) begin
            // Stalled with a beat in flight from upstream: park it.
            skid_d     = in_data;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
endmodule

// File: rtl/group_denorm_2d.sv
// Group denormalization x = y * sigma + mu over COMPUTE_DIM0*COMPUTE_DIM1 lane
// tiles. Stats are taken once per group of NUM_ITERS beats; the next group's
// stats may load on the last beat of the current group with no bubble.
//   stat_mu/stat_sigma/stat_valid/stat_ready : per-group statistics channel
//   in_data/in_valid/in_ready                : normalized tile input
//   out_data/out_valid/out_ready             : reconstructed tile output
module group_denorm_2d
    import group_denorm_pkg::*;
#(
    parameter int TOTAL_DIM0      = DEF_TOTAL_DIM0,
    parameter int TOTAL_DIM1      = DEF_TOTAL_DIM1,
    parameter int COMPUTE_DIM0    = DEF_COMPUTE_DIM0,
    parameter int COMPUTE_DIM1    = DEF_COMPUTE_DIM1,
    parameter int GROUP_CHANNELS  = DEF_GROUP_CHANNELS,
    parameter int IN_WIDTH        = DEF_IN_WIDTH,
    parameter int IN_FRAC_WIDTH   = DEF_IN_FRAC_WIDTH,
    parameter int STAT_WIDTH      = DEF_STAT_WIDTH,
    parameter int STAT_FRAC_WIDTH = DEF_STAT_FRAC_WIDTH,
    parameter int OUT_WIDTH       = DEF_OUT_WIDTH,
    parameter int OUT_FRAC_WIDTH  = DEF_OUT_FRAC_WIDTH,
    localparam int NUM_LANES      = COMPUTE_DIM0 * COMPUTE_DIM1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [STAT_WIDTH-1:0]                stat_mu,
    input  logic [STAT_WIDTH-1:0]                stat_sigma,
    input  logic                                 stat_valid,
    output logic                                 stat_ready,
    input  logic [NUM_LANES-1:0][IN_WIDTH-1:0]   in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [NUM_LANES-1:0][OUT_WIDTH-1:0]  out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready
);
    localparam int ITERS = calc_num_iters(TOTAL_DIM0, TOTAL_DIM1,
                                          COMPUTE_DIM0, COMPUTE_DIM1, GROUP_CHANNELS);
    localparam int CNT_W = calc_cnt_width(ITERS);
    localparam int PW    = IN_WIDTH + STAT_WIDTH + 1;
    localparam int PFW   = IN_FRAC_WIDTH + STAT_FRAC_WIDTH;
    localparam int SW    = PW + 1;
    localparam int S1_W  = STAT_WIDTH + NUM_LANES * PW;
    localparam int S2_W  = NUM_LANES * OUT_WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [STAT_WIDTH-1:0]   mu_q, mu_d, sigma_q, sigma_d;

    logic                            s1_in_ready, s1_valid, s2_in_ready;
    logic [S1_W-1:0]                 s1_out;
    logic [NUM_LANES-1:0][PW-1:0]    prod_c, s1_prod;
    logic [STAT_WIDTH-1:0]           s1_mu;
    logic [NUM_LANES-1:0][OUT_WIDTH-1:0] res_c;
    logic [S2_W-1:0]                 s2_out;

    // Control: the stat regs feed stage 1 alongside each beat, so reloading
    // them on the last beat's edge only affects the following group.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mu_d       = mu_q;
        sigma_d    = sigma_q;
        stat_ready = 1'b0;
        in_ready   = 1'b0;
        case (state_q)
            LOAD: begin
                stat_ready = 1'b1;
                if (stat_valid) begin
                    mu_d    = stat_mu;
                    sigma_d = stat_sigma;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                in_ready = s1_in_ready;
                if (in_valid && s1_in_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d      = '0;
                        stat_ready = 1'b1;
                        if (stat_valid) begin
                            mu_d    = stat_mu;
                            sigma_d = stat_sigma;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            mu_q    <= '0;
            sigma_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mu_q    <= mu_d;
            sigma_q <= sigma_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        group_denorm_lane #(
            .IN_WIDTH       (IN_WIDTH),
            .IN_FRAC_WIDTH  (IN_FRAC_WIDTH),
            .STAT_WIDTH     (STAT_WIDTH),
            .OUT_WIDTH      (OUT_WIDTH),
            .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH),
            .PROD_WIDTH     (PW),
            .PROD_FRAC_WIDTH(PFW),
            .SUM_WIDTH      (SW)
        ) u_lane (
            .y      (in_data[i]),
            .sigma  (sigma_q),
            .prod   (prod_c[i]),
            .prod_s1(s1_prod[i]),
            .mu_s1  (s1_mu),
            .res    (res_c[i])
        );
    end

    // Stage 1: products plus the mu that belongs to this beat's group.
    skid_buffer #(.WIDTH(S1_W)) u_s1 (
        .clk      (clk),
        .rst_n    (rst),
        .in_data  ({mu_q, prod_c}),
        .in_valid (in_valid && in_ready),
        .in_ready (s1_in_ready),
        .out_data (s1_out),
        .out_valid(s1_valid),
        .out_ready(s2_in_ready)
    );
    assign {s1_mu, s1_prod} = s1_out;

    // Stage 2: add + cast result; its output register is out_data.
    skid_buffer #(.WIDTH(S2_W)) u_s2 (
        .clk      (clk),
        .rst_n    (rst),
        .in_data  (res_c),
        .in_valid (s1_valid),
        .in_ready (s2_in_ready),
        .out_data (s2_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );
    assign out_data = s2_out;
endmodule

// File: tb/tb_group_denorm_2d.sv
module tb_group_denorm_2d;
    localparam int NL    = 4;
    localparam int ITERS = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [7:0]          stat_mu, stat_sigma;
    logic                stat_valid, stat_ready;
    logic [NL-1:0][7:0]  in_data;
    logic                in_valid, in_ready;
    logic [NL-1:0][7:0]  out_data;
    logic                out_valid, out_ready;

    always #5 clk = ~clk;

    group_denorm_2d dut (
        .clk       (clk),
        .rst       (rst),
        .stat_mu   (stat_mu),
        .stat_sigma(stat_sigma),
        .stat_valid(stat_valid),
        .stat_ready(stat_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    logic [15:0] sq[$];    // stats waiting to be offered {mu, sigma}
    logic [15:0] mst[$];   // stats accepted, one per group in order
    logic [31:0] bq[$];    // beats waiting to be offered
    logic [31:0] expq[$];  // expected outputs in order
    int          accq[$];  // accept cycle of each expected output
    int          n_chk = 0, n_fail = 0, cyc = 0, beats_acc = 0;
    int          in_pct = 100, or_pct = 100;
    bit          lat_chk = 0, held = 0;
    logic [31:0] held_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // x = y*sigma + mu in real-valued terms, scaled by 2^8; floor to 2^-4, saturate.
    function automatic logic [7:0] ref_lane(input logic [7:0] y, input logic [7:0] mu,
                                            input logic [7:0] sg);
        int x;
        x = int'($signed(y)) * int'({24'd0, sg}) + int'($signed(mu)) * 16;
        x = x >>> 4;
        if (x > 127)  x = 127;
        if (x < -128) x = -128;
        return x[7:0];
    endfunction

    function automatic logic [31:0] ref_tile(input logic [31:0] t, input logic [15:0] st);
        logic [31:0] r;
        for (int l = 0; l < NL; l++) r[l*8 +: 8] = ref_lane(t[l*8 +: 8], st[15:8], st[7:0]);
        return r;
    endfunction

    task automatic tick();
        logic hs_s, hs_i, hs_o;
        int   g, a;
        @(negedge clk);
        cyc++;
        stat_valid = (sq.size() > 0);
        if (stat_valid) {stat_mu, stat_sigma} = sq[0];
        in_valid = (bq.size() > 0) && ($urandom_range(99) < in_pct);
        if (bq.size() > 0) in_data = bq[0];
        out_ready = ($urandom_range(99) < or_pct);
        #1;
        if (held) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", out_data, held_data);
        end
        held      = out_valid && !out_ready;
        held_data = out_data;
        hs_s = stat_valid && stat_ready;
        hs_i = in_valid && in_ready;
        hs_o = out_valid && out_ready;
        if (hs_o) begin
            if (expq.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
            else begin
                chk("out_data", out_data, expq.pop_front());
                a = accq.pop_front();
                if (lat_chk) chk("latency", cyc - a, 32'd2);
            end
        end
        if (hs_s) begin
            // Stats for the next group must load exactly with the previous group's
            // last beat; stats for a fresh session load with no beat in flight.
            if (beats_acc < ITERS * mst.size())
                chk("zero_bubble", {30'd0, hs_i, 1'(beats_acc % ITERS == 7)}, 32'd3);
            else
                chk("load_no_beat", {31'd0, hs_i}, 32'd0);
        end
        if (hs_i) begin
            g = beats_acc / ITERS;
            if (g >= mst.size()) chk("beat_without_stats", {31'd0, in_ready}, 32'd0);
            else begin
                expq.push_back(ref_tile(bq[0], mst[g]));
                accq.push_back(cyc);
            end
            void'(bq.pop_front());
            beats_acc++;
        end
        if (hs_s) mst.push_back(sq.pop_front());
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((bq.size() > 0 || expq.size() > 0 || sq.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        if (bq.size() > 0 || expq.size() > 0 || sq.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout beats=%0d outs=%0d stats=%0d",
                     bq.size(), expq.size(), sq.size());
        end
    endtask

    task automatic push_rand_group();
        sq.push_back(16'($urandom));
        for (int i = 0; i < ITERS; i++) bq.push_back($urandom);
    endtask

    initial begin
        int base, n;
        stat_mu = '0; stat_sigma = '0; stat_valid = 0;
        in_data = '0; in_valid = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stat_ready", {31'd0, stat_ready}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1;

        // Basic: 0.5 + 1.0*2.0 = 2.5 everywhere, 2-cycle latency.
        sq.push_back(16'h0820);
        repeat (ITERS) bq.push_back(32'h10101010);
        lat_chk = 1;
        drain(200);
        lat_chk = 0;

        // Negative values and floor rounding.
        sq.push_back(16'h0008);
        repeat (ITERS) bq.push_back(32'h00F0FF01);
        drain(200);

        // Saturation at both ends.
        sq.push_back(16'h1040);
        for (int i = 0; i < ITERS; i++) bq.push_back(i[0] ? 32'h7F7F8080 : 32'h807F807F);
        drain(200);

        // Group boundary with both stats presented up front.
        push_rand_group();
        push_rand_group();
        lat_chk = 1;
        drain(300);
        lat_chk = 0;

        // Random in_valid and out_ready over 4 groups.
        in_pct = 70; or_pct = 50;
        repeat (4) push_rand_group();
        drain(2000);

        // Reset partway through a group.
        in_pct = 100; or_pct = 100;
        push_rand_group();
        base = beats_acc; n = 0;
        while (beats_acc - base < 4 && n < 100) begin tick(); n++; end
        chk("pre_rst_beats", beats_acc - base, 32'd4);
        @(negedge clk);
        rst = 0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_stat_ready", {31'd0, stat_ready}, 32'd1);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        sq.delete(); bq.delete(); expq.delete(); accq.delete(); mst.delete();
        beats_acc = 0; held = 0;
        stat_valid = 0; in_valid = 0;
        @(negedge clk);
        rst = 1;
        or_pct = 50;
        push_rand_group();
        drain(500);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
